// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: snapshots live time into shadow registers, edits the
// selected field with wrap-around, then parallel-loads the counters on exit.
module time_set_ctrl #(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  input  logic       blink_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic [2:0] disp_on
);

  // state  | meaning
  // RUN    | counters advance, display fully on
  // EDIT   | counters paused, inc/dec applied to the field chosen by mode
  // COMMIT | single cycle: load strobe drives shadows into the counters
  typedef enum logic [1:0] {RUN, EDIT, COMMIT} state_t;

  localparam logic [5:0] HOUR_TOP = 6'(HOUR_MAX);
  localparam logic [5:0] MIN_TOP  = 6'(MIN_MAX);

  state_t     state, state_nxt;
  logic       run_en_nxt, load_nxt;
  logic [4:0] set_hour_nxt;
  logic [5:0] set_min_nxt, set_sec_nxt;
  logic       blink_phase, blink_phase_nxt;
  logic [1:0] mode_q, mode_q_nxt;
  logic       step_ok, field_change;

  // Out-of-range values (corrupt live time) land on 0 going up, on max going down.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                            input logic up);
    if (up) return (v >= top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > top) ? top : v - 6'd1;
  endfunction

  assign step_ok      = inc_pulse ^ dec_pulse;
  assign field_change = (mode != mode_q);

  always_comb begin
    state_nxt       = state;
    run_en_nxt      = run_en;
    load_nxt        = 1'b0;
    set_hour_nxt    = set_hour;
    set_min_nxt     = set_min;
    set_sec_nxt     = set_sec;
    blink_phase_nxt = blink_phase;
    mode_q_nxt      = mode;
    case (state)
      RUN: begin
        run_en_nxt      = 1'b1;
        blink_phase_nxt = 1'b1;
        if (mode != 2'b00) begin
          state_nxt    = EDIT;
          run_en_nxt   = 1'b0;
          set_hour_nxt = cur_hour;
          set_min_nxt  = cur_min;
          set_sec_nxt  = cur_sec;
        end
      end
      EDIT: begin
        run_en_nxt = 1'b0;
        if (mode == 2'b00) begin
          state_nxt = COMMIT;
          load_nxt  = 1'b1;
        end else begin
          if (step_ok) begin
            case (mode)
              2'b01:   set_hour_nxt = 5'(step_field({1'b0, set_hour}, HOUR_TOP, inc_pulse));
              2'b10:   set_min_nxt  = step_field(set_min, MIN_TOP, inc_pulse);
              default: set_sec_nxt  = step_field(set_sec, MIN_TOP, inc_pulse);
            endcase
          end
          if (step_ok || field_change) blink_phase_nxt = 1'b1;
          else if (blink_tick)         blink_phase_nxt = ~blink_phase;
        end
      end
      COMMIT: begin
        state_nxt       = RUN;
        run_en_nxt      = 1'b1;
        blink_phase_nxt = 1'b1;
      end
      default: begin
        state_nxt  = RUN;
        run_en_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= RUN;
      run_en      <= 1'b1;
      load        <= 1'b0;
      set_hour    <= '0;
      set_min     <= '0;
      set_sec     <= '0;
      blink_phase <= 1'b1;
      mode_q      <= 2'b00;
    end else begin
      state       <= state_nxt;
      run_en      <= run_en_nxt;
      load        <= load_nxt;
      set_hour    <= set_hour_nxt;
      set_min     <= set_min_nxt;
      set_sec     <= set_sec_nxt;
      blink_phase <= blink_phase_nxt;
      mode_q      <= mode_q_nxt;
    end
  end

  always_comb begin
    disp_on = 3'b111;
    if (state == EDIT) begin
      case (mode)
        2'b01:   disp_on[2] = blink_phase;
        2'b10:   disp_on[1] = blink_phase;
        2'b11:   disp_on[0] = blink_phase;
        default: disp_on = 3'b111;
      endcase
    end
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences the clock's time-setting flow from the 2-bit mode selector.
- In a set mode it pauses the timekeeping counters and snapshots the current time into shadow registers. It then applies debounced inc/dec pulses to the selected field with wrap-around.
- On return to run mode it issues a one-cycle parallel load to the counters.
- Drives per-field blink enables for the display.

Parameters:
HOUR_MAX, 23, highest hour value; hour wraps HOUR_MAX<->0
MIN_MAX, 59, highest minute/second value; min/sec wrap MIN_MAX<->0

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-high
mode  input  2  00 run, 01 set hour, 10 set minute, 11 set second
inc_pulse  input  1  one-cycle pulse, already debounced: increment selected field
dec_pulse  input  1  one-cycle pulse, already debounced: decrement selected field
blink_tick  input  1  one-cycle enable at blink half-period rate
cur_hour  input  5  live hour from counters
cur_min  input  6  live minute from counters
cur_sec  input  6  live second from counters
run_en  output  1  counters may advance
load  output  1  one-cycle parallel-load strobe to counters
set_hour  output  5  shadow hour (load data / display in edit)
set_min  output  6  shadow minute
set_sec  output  6  shadow second
disp_on  output  3  {hour,min,sec} display enables (0 = blanked)

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state RUN, run_en=1, load=0, shadows=0, blink_phase=1, disp_on=3'b111.
  - Reset during EDIT or COMMIT discards the edit; no load is issued.
- Registered FSM with states RUN, EDIT, COMMIT. All outputs are registered except disp_on, which is decoded combinationally from state, mode and blink_phase.
- RUN:
  - run_en=1, disp_on=111.
  - If mode!=00 at edge n: shadows <= cur_hour/min/sec sampled in cycle n, then go to EDIT.
  - From cycle n+1: run_en=0, blink_phase=1.
  - inc/dec are ignored in RUN and in the transition cycle.
- EDIT:
  - run_en=0.
  - The selected field follows the current-cycle mode (01 hour, 10 min, 11 sec).
  - inc_pulse alone: field+1, wrapping at max to 0.
  - dec_pulse alone: field-1, wrapping at 0 to max.
  - inc and dec both asserted: no change.
  - Any applied inc/dec forces blink_phase=1; otherwise blink_tick toggles blink_phase.
  - disp_on: selected field = blink_phase, other fields = 1.
  - Changing between set modes keeps all shadows and resets blink_phase=1.
  - mode==00 at edge n: go to COMMIT. inc/dec in that cycle are ignored.
- COMMIT:
  - Lasts exactly one cycle (cycle n+1): load=1, run_en=0, set_* stable and valid, disp_on=111.
  - Always returns to RUN at the next edge regardless of mode, so run_en=1 from n+2.
  - A non-zero mode seen in RUN at n+2 re-enters EDIT with a fresh snapshot.
- load is never asserted outside COMMIT and is never asserted for two consecutive cycles.
- Arithmetic:
  - Field width is preserved with no overflow into neighbouring fields.
  - Shadow values outside range (corrupt cur_*) wrap to 0 on inc and to max on dec.
- Latency: mode change to run_en deassert is 1 cycle; mode=00 to load is 1 cycle; load to run_en reassert is 1 cycle.

Test Plan:
- Reset, then cur=12:34:56, mode=01 -> next cycle run_en=0, set_hour=12, set_min=34, set_sec=56, disp_on[2] toggles on each blink_tick.
- In mode 01 with set_hour=23, one inc_pulse -> set_hour=0. Then one dec_pulse -> set_hour=23. disp_on[2]=1 in the cycle after each pulse.
- mode 10, set_min=0, dec_pulse -> 59. inc and dec in the same cycle -> stays 59. Switch to mode 11 -> set_min holds 59 and the inc/dec target is sec.
- After edits giving 05:07:09, mode=00 -> exactly one load cycle with set_*=5/7/9, then run_en=1. No further load while mode stays 00.
- rst_n=1 asserted mid-EDIT after edits -> no load pulse, run_en=1, shadows=0, state RUN.
- mode returns to 01 during the COMMIT cycle -> load still pulses once, run_en=1 for one cycle, then EDIT with a snapshot of the newly loaded time.
